// File: rtl/soc_system_pio_pkg.sv
// Shared definitions for the HPS-side parallel I/O ports: register word
// addresses and the edge-capture selection encoding.
package soc_system_pio_pkg;

    localparam logic [1:0] PIO_ADDR_DATA = 2'd0;
    localparam logic [1:0] PIO_ADDR_DIR  = 2'd1;
    localparam logic [1:0] PIO_ADDR_MASK = 2'd2;
    localparam logic [1:0] PIO_ADDR_EDGE = 2'd3;

    typedef enum logic [1:0] {
        EDGE_RISING  = 2'd0,
        EDGE_FALLING = 2'd1,
        EDGE_ANY     = 2'd2
    } pio_edge_e;

endpackage

// File: rtl/soc_system_pio_in_if.sv
// Avalon-MM slave bus bundle for the input PIO (word address, select,
// active-low write strobe, write data and registered read data).
interface soc_system_pio_in_if;

    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata
    );

endinterface

// File: rtl/soc_system_pio_debounce.sv
// One input pin: two-flop synchronizer followed by a consecutive-sample
// debounce counter; a zero cycle count passes the synchronized level through.
module soc_system_pio_debounce #(
    parameter int   DEBOUNCE_CYCLES = 50000,
    parameter logic IDLE_VALUE      = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic pin,
    output logic level
);

    logic sync_meta;
    logic sync_out;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_meta <= IDLE_VALUE;
            sync_out  <= IDLE_VALUE;
        end else begin
            sync_meta <= pin;
            sync_out  <= sync_meta;
        end
    end

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_bypass
            assign level = sync_out;
        end else begin : g_count
            localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
            localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

            logic [CW-1:0] count;
            logic          stable;

            // Any sample agreeing with the accepted level restarts the run,
            // so only an unbroken disagreement of full length is accepted.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    count  <= '0;
                    stable <= IDLE_VALUE;
                end else if (sync_out == stable) begin
                    count <= '0;
                end else if (count == LAST) begin
                    stable <= sync_out;
                    count  <= '0;
                end else begin
                    count <= count + CW'(1);
                end
            end

            assign level = stable;
        end
    endgenerate

endmodule

// File: rtl/soc_system_pio_in.sv
// Avalon-MM parallel input port: debounced pin levels, edge capture with
// write-1-to-clear, interrupt mask and a maskable level interrupt.
module soc_system_pio_in
    import soc_system_pio_pkg::*;
#(
    parameter int               WIDTH           = 4,
    parameter int               DEBOUNCE_CYCLES = 50000,
    parameter pio_edge_e        EDGE_TYPE       = EDGE_FALLING,
    parameter logic [WIDTH-1:0] IDLE_VALUE      = '1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [WIDTH-1:0]      in_port,
    soc_system_pio_in_if.slave    bus,
    output logic                  irq
);

    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] stable_d;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] edge_capture;
    logic [WIDTH-1:0] edge_hits;
    logic [WIDTH-1:0] edge_clear;
    logic [WIDTH-1:0] edge_next;
    logic [31:0]      read_mux;
    logic             wr_en;
    logic             unused_wdata;

    for (genvar i = 0; i < WIDTH; i++) begin : g_pin
        soc_system_pio_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .IDLE_VALUE      (IDLE_VALUE[i])
        ) u_debounce (
            .clk     (clk),
            .reset_n (reset_n),
            .pin     (in_port[i]),
            .level   (stable[i])
        );
    end

    assign wr_en        = bus.chipselect && !bus.write_n;
    assign unused_wdata = &{1'b0, bus.writedata};

    always_comb begin
        edge_hits = '0;
        case (EDGE_TYPE)
            EDGE_RISING:  edge_hits = stable & ~stable_d;
            EDGE_FALLING: edge_hits = ~stable & stable_d;
            EDGE_ANY:     edge_hits = stable ^ stable_d;
            default:      edge_hits = '0;
        endcase
    end

    // New edges are ORed in after the clear so a coincident edge survives.
    always_comb begin
        edge_clear = '0;
        if (wr_en && bus.address == PIO_ADDR_EDGE) begin
            edge_clear = bus.writedata[WIDTH-1:0];
        end
        edge_next = (edge_capture & ~edge_clear) | edge_hits;
    end

    always_comb begin
        read_mux = '0;
        if (bus.chipselect) begin
            case (bus.address)
                PIO_ADDR_DATA: read_mux[WIDTH-1:0] = stable;
                PIO_ADDR_MASK: read_mux[WIDTH-1:0] = irq_mask;
                PIO_ADDR_EDGE: read_mux[WIDTH-1:0] = edge_capture;
                default:       read_mux = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stable_d     <= IDLE_VALUE;
            irq_mask     <= '0;
            edge_capture <= '0;
            bus.readdata <= '0;
        end else begin
            stable_d     <= stable;
            edge_capture <= edge_next;
            bus.readdata <= read_mux;
            if (wr_en && bus.address == PIO_ADDR_MASK) begin
                irq_mask <= bus.writedata[WIDTH-1:0];
            end
        end
    end

    assign irq = |(edge_capture & irq_mask);

endmodule
